dbus_arbiter: RTL

- Shares the single data bus (RAM, UART at 0xExxxxxxx, teleprinter at 0x8xxxxxxx) between two masters.
- Master 0 is the cpu32 data port; master 1 is a secondary requester (loader/DMA).
- Uses round-robin arbitration, a req/ack handshake per master, one-hot slave select decode and registered read-data return.
- Sits between the masters and the ram/uart/teleprinter instances at system top level.

---
 rtl/dbus_pkg.sv | 18 +
 rtl/dbus_decode.sv | 20 ++
 rtl/dbus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus arbiter and its address decoder:
// FSM state encoding, one-hot slave select codes and address region nibbles.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_RAM  = 3'b001;
    localparam logic [2:0] SEL_UART = 3'b010;
    localparam logic [2:0] SEL_TTY  = 3'b100;

    localparam logic [3:0] REGION_UART = 4'hE;
    localparam logic [3:0] REGION_TTY  = 4'h8;

endpackage

// File: rtl/dbus_decode.sv
// Address region decoder: top address nibble -> one-hot slave select.
// Also used at system level to derive the uart/teleprinter chip selects.
module dbus_decode
    import dbus_pkg::*;
(
    input  logic [3:0] region,
    output logic [2:0] sel
);

    // UART and teleprinter own one region each; everything else is RAM.
    always_comb begin
        sel = SEL_RAM;
        case (region)
            REGION_UART: sel = SEL_UART;
            REGION_TTY:  sel = SEL_TTY;
            default:     sel = SEL_RAM;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus (RAM/UART/TTY).
// Optional bus locking is compiled in with the macro DBUS_ARB_LOCK_EN.
//
// Handshake: a master raises mN_req with we/addr/wdata and holds all of them
// until it sees mN_ack. mN_ack is a one-cycle pulse in the DONE cycle, and
// mN_rdata is valid in that cycle and stays stable until the next ack.
// Each transfer takes IDLE -> XFER -> DONE; IDLE is the turnaround cycle,
// so the master has time to drop req before it could be granted again.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
`ifdef DBUS_ARB_LOCK_EN
    input  logic          m0_lock,
    input  logic          m1_lock,
`endif
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] s_addr,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    output logic [2:0]    s_sel,
    input  logic [DW-1:0] s_rdata,
    output logic [1:0]    dbg_state
);

    state_t        state;
    logic          gnt;        // 0 = master 0, 1 = master 1
    logic          last_gnt;
    logic [DW-1:0] rdata_q;

    logic          start;
    logic          pick;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_we;
    logic [2:0]    dec_sel;

`ifdef DBUS_ARB_LOCK_EN
    logic          locked;
    logic          lock_owner;
    logic          own_hold;
    logic          g_lock;

    assign g_lock   = gnt ? m1_lock : m0_lock;
    assign own_hold = locked && (lock_owner ? (m1_req && m1_lock) : (m0_req && m0_lock));
`endif

    assign dbg_state = state;

    // Granted master's request fields, muxed on the registered grant.
    assign g_addr  = gnt ? m1_addr  : m0_addr;
    assign g_wdata = gnt ? m1_wdata : m0_wdata;
    assign g_we    = gnt ? m1_we    : m0_we;

    dbus_decode u_decode (
        .region (g_addr[AW-1:AW-4]),
        .sel    (dec_sel)
    );

    // Arbitration choice for the IDLE cycle: lock owner first, then round-robin.
    always_comb begin
        start = 1'b0;
        pick  = gnt;
`ifdef DBUS_ARB_LOCK_EN
        if (own_hold) begin
            start = 1'b1;
            pick  = lock_owner;
        end else
`endif
        if (m0_req && m1_req) begin
            start = 1'b1;
            pick  = ~last_gnt;
        end else if (m0_req) begin
            start = 1'b1;
            pick  = 1'b0;
        end else if (m1_req) begin
            start = 1'b1;
            pick  = 1'b1;
        end
    end

    // Transfer sequencer: grant in IDLE, address cycle, completion cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            rdata_q  <= '0;
`ifdef DBUS_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef DBUS_ARB_LOCK_EN
                    if (locked && !own_hold) locked <= 1'b0;
`endif
                    if (start) begin
                        gnt   <= pick;
                        state <= XFER;
                    end
                end
                XFER: state <= DONE;
                DONE: begin
                    rdata_q  <= s_rdata;
                    last_gnt <= gnt;
`ifdef DBUS_ARB_LOCK_EN
                    if (g_lock) begin
                        locked     <= 1'b1;
                        lock_owner <= gnt;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus and master-side outputs derived from the registered state and grant.
    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_sel    = '0;
        s_we     = 1'b0;
        if (state == XFER || state == DONE) begin
            s_addr  = g_addr;
            s_wdata = g_wdata;
            s_sel   = dec_sel;
        end
        if (state == XFER) s_we = g_we;
        m0_ack   = (state == DONE) && !gnt;
        m1_ack   = (state == DONE) && gnt;
        m0_rdata = m0_ack ? s_rdata : rdata_q;
        m1_rdata = m1_ack ? s_rdata : rdata_q;
    end

endmodule
